// File: rtl/hazard_controller_pkg.sv
// Shared pipeline definitions for the hazard controller: FSM state encoding
// and register-file constants.
package hazard_controller_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } hc_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// Bundle of pipeline hazard inputs and stall/flush controls between the
// pipeline (master) and the hazard controller (slave).
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    import hazard_controller_pkg::*;

    logic             id_ex_mem_read;
    logic [REG_W-1:0] id_ex_rt;
    logic [REG_W-1:0] if_id_rs;
    logic [REG_W-1:0] if_id_rt;
    logic             if_id_uses_rt;
    logic             branch_taken;
    logic             dmem_busy;
    logic             hazard_signal_mux;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             pipe_freeze;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, dmem_busy,
        input  hazard_signal_mux, pc_write, if_id_write, if_id_flush,
               pipe_freeze, mem_timeout, stall_count
    );

    modport slave (
        input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt, if_id_uses_rt,
               branch_taken, dmem_busy,
        output hazard_signal_mux, pc_write, if_id_write, if_id_flush,
               pipe_freeze, mem_timeout, stall_count
    );

endinterface

// File: rtl/hazard_controller_load_use_detect.sv
// Load-use comparator: the ID instruction reads the register a load in EX
// is about to write. Register 0 never creates a dependence.
module load_use_detect
    import hazard_controller_pkg::*;
(
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             if_id_uses_rt,
    output logic             load_use
);

    assign load_use = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && (id_ex_rt == if_id_rt)));

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait freezes,
// branch flushes, a sticky memory-timeout flag and a saturating stall counter.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input logic                clk,
    input logic                rst,
    hazard_controller_if.slave bus
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_SAT   = WAIT_W'(MAX_WAIT + 1);

    hc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    logic load_use;
    logic hazard_signal_mux, pc_write, if_id_write, if_id_flush, pipe_freeze;

    load_use_detect u_load_use_detect (
        .id_ex_mem_read (bus.id_ex_mem_read),
        .id_ex_rt       (bus.id_ex_rt),
        .if_id_rs       (bus.if_id_rs),
        .if_id_rt       (bus.if_id_rt),
        .if_id_uses_rt  (bus.if_id_uses_rt),
        .load_use       (load_use)
    );

    // Priority: memory wait over load-use bubble over branch flush. The bubble
    // is never repeated from LOAD_STALL, so each load-use costs one cycle.
    always_comb begin
        state_d           = state_q;
        hazard_signal_mux = 1'b0;
        pc_write          = 1'b1;
        if_id_write       = 1'b1;
        if_id_flush       = 1'b0;
        pipe_freeze       = 1'b0;
        if (rst) begin
            state_d = RUN;
        end else if (bus.dmem_busy) begin
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_d     = MEM_WAIT;
        end else if (load_use && (state_q != LOAD_STALL)) begin
            hazard_signal_mux = 1'b1;
            pc_write          = 1'b0;
            if_id_write       = 1'b0;
            state_d           = LOAD_STALL;
        end else begin
            if_id_flush = bus.branch_taken;
            state_d     = RUN;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (!pc_write && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
        wait_cnt_d = '0;
        if (pipe_freeze) begin
            wait_cnt_d = (wait_cnt_q == WAIT_SAT) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end
        // Set on the busy cycle that pushes the consecutive count past MAX_WAIT.
        mem_timeout_d = mem_timeout_q || (pipe_freeze && (wait_cnt_q >= WAIT_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            stall_count_q <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.hazard_signal_mux = hazard_signal_mux;
    assign bus.pc_write          = pc_write;
    assign bus.if_id_write       = if_id_write;
    assign bus.if_id_flush       = if_id_flush;
    assign bus.pipe_freeze       = pipe_freeze;
    assign bus.mem_timeout       = mem_timeout_q;
    assign bus.stall_count       = stall_count_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: load-use, register 0, rt use,
// memory wait, timeout, priority and reset abandonment.
module tb_hazard_controller;
    import hazard_controller_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hazard_controller_if #(.CNT_W(16)) bus ();

    hazard_controller #(.MAX_WAIT(15), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {hazard_signal_mux, pc_write, if_id_write, if_id_flush, pipe_freeze}
    logic [4:0] ctl;
    assign ctl = {bus.hazard_signal_mux, bus.pc_write, bus.if_id_write,
                  bus.if_id_flush, bus.pipe_freeze};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses, input logic br,
                         input logic busy);
        bus.id_ex_mem_read = mr;
        bus.id_ex_rt       = ex_rt;
        bus.if_id_rs       = rs;
        bus.if_id_rt       = rt;
        bus.if_id_uses_rt  = uses;
        bus.branch_taken   = br;
        bus.dmem_busy      = busy;
        #3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        // Reset cycle overrides a busy memory and a load-use
        rst = 1'b1;
        drive(1, 5, 5, 0, 0, 1, 1);
        chk("rst_ctl", ctl, 5'b01100);
        tick();
        chk("rst_stall_count", bus.stall_count, 0);
        chk("rst_timeout", bus.mem_timeout, 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("idle_ctl", ctl, 5'b01100);
        tick();

        // lw $5 in EX, add rs=5 in ID
        drive(1, 5, 5, 0, 0, 0, 0);
        chk("lu_rs_bubble", ctl, 5'b10000);
        tick();
        chk("lu_rs_ignored_in_stall", ctl, 5'b01100);
        chk("lu_rs_count", bus.stall_count, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_rs_back_run", ctl, 5'b01100);

        // Load to $0 never stalls
        drive(1, 0, 0, 0, 1, 0, 0);
        chk("reg0_no_stall", ctl, 5'b01100);
        tick();
        chk("reg0_count", bus.stall_count, 1);

        // rt dependence only when the ID instruction reads rt
        drive(1, 7, 3, 7, 0, 0, 0);
        chk("rt_unused_no_stall", ctl, 5'b01100);
        drive(1, 7, 3, 7, 1, 0, 0);
        chk("rt_used_stall", ctl, 5'b10000);
        tick();
        chk("rt_count", bus.stall_count, 2);
        drive(1, 7, 3, 7, 1, 1, 0);
        chk("branch_in_load_stall", ctl, 5'b01110);
        tick();

        // Branch with load-use: bubble wins, no flush; then flush in LOAD_STALL
        drive(1, 7, 7, 0, 0, 1, 0);
        chk("prio_lu_over_branch", ctl, 5'b10000);
        tick();
        chk("prio_count", bus.stall_count, 3);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("prio_branch_flush_stall", ctl, 5'b01110);
        tick();
        chk("branch_run_flush", ctl, 5'b01110);
        tick();

        // Three busy cycles, the first with load-use and branch also present
        drive(1, 5, 5, 0, 0, 1, 1);
        chk("busy1_prio", ctl, 5'b00001);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("busy2", ctl, 5'b00001);
        tick();
        chk("busy3", ctl, 5'b00001);
        tick();
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("busy_exit_run_flush", ctl, 5'b01110);
        chk("busy_count", bus.stall_count, 6);
        chk("busy_no_timeout", bus.mem_timeout, 0);
        tick();

        // Sixteen busy cycles with MAX_WAIT=15 trips the sticky timeout
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 0, 0, 0, 0, 1);
            if (i == 15) begin
                chk("to_freeze_16th", ctl, 5'b00001);
                chk("to_not_yet_after_15", bus.mem_timeout, 0);
            end
            tick();
        end
        chk("to_set", bus.mem_timeout, 1);
        chk("to_count", bus.stall_count, 22);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("to_exit_ctl", ctl, 5'b01100);
        tick();
        tick();
        chk("to_sticky", bus.mem_timeout, 1);

        // Reset in the middle of MEM_WAIT
        drive(0, 0, 0, 0, 0, 0, 1);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("rst_mid_wait_ctl", ctl, 5'b01100);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_mid_wait_timeout", bus.mem_timeout, 0);
        chk("rst_mid_wait_count", bus.stall_count, 0);
        chk("rst_mid_wait_run", ctl, 5'b01100);
        tick();

        // Reset in LOAD_STALL: FSM back in RUN, so a load-use bubbles again
        drive(1, 9, 9, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        drive(1, 9, 9, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        drive(1, 9, 9, 0, 0, 0, 0);
        chk("rst_mid_stall_count", bus.stall_count, 0);
        chk("rst_mid_stall_rebubble", ctl, 5'b10000);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
